dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Load/store sequencer between the core's memory stage and the word-addressed data memory (1024 x 32, combinational read, write on posedge clk when WE).
- Accepts byte/halfword/word load and store requests over a valid/ready handshake.
- Performs read-modify-write for sub-word stores and sign/zero-extends sub-word loads.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
DEPTH, 1024, number of 32-bit words in the attached data memory; word index = addr[31:2]
AW, 32, request address width

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  AW  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  1 = misaligned, illegal size or out of range
mem_a  output  32  address to data memory (byte address, word-aligned)
mem_wd  output  32  write data to data memory
mem_we  output  1  write enable to data memory
mem_rd  input  32  read data from data memory

Behaviour:
- Reset (rst=0, async): state=IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0; mem_a=0, mem_wd=0, mem_we=0. Asserting reset mid-operation aborts it immediately. mem_we is decoded from state, so it drops the same instant; no partial write occurs after reset asserts.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, capture we/size/unsigned/addr/wdata.
- Error check at acceptance; an error goes to RESP with rsp_err=1 and no memory access. Error conditions:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:2] >= DEPTH
- Legal accept transitions:
  - load -> LOAD
  - word store -> WRITE
  - byte/half store -> RMW_RD
- LOAD: mem_a={addr[31:2],2'b00}. Select lane by addr[1:0] (byte) or addr[1] (half), extend per unsigned, register into rsp_rdata. -> RESP.
- RMW_RD: drive mem_a; register mem_rd into old_word. -> WRITE.
- WRITE: mem_a held, mem_we=1 for exactly one cycle.
  - Word store: mem_wd=wdata.
  - Sub-word store: mem_wd=old_word with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - Then -> RESP with rsp_rdata=0.
- RESP: rsp_valid=1; outputs stable until rsp_valid&rsp_ready; then -> IDLE. req_ready=0 in every state except IDLE.
- No pipelining: one outstanding request. Back-to-back throughput is one request per (latency+1) cycles with rsp_ready held high.
- Latency, accept edge T to rsp_valid high:
  - error: T+1
  - load: T+2
  - word store: T+2
  - sub-word store: T+3
- Outside LOAD/RMW_RD/WRITE: mem_a=0, mem_we=0, mem_wd=0.
- Lane mapping is little-endian: byte k = word[8k+7:8k].

Test Plan:
- Reset with rst=0 mid-WRITE of a word store -> mem_we falls without waiting for clk; word unchanged; after release req_ready=1, rsp_valid=0.
- Store word 0xDEADBEEF @0x10, then load word @0x10 -> store rsp at T+2, err=0; load rsp_rdata=0xDEADBEEF at T+2.
- Store byte 0x7F @0x11 over 0xDEADBEEF -> exactly one RMW_RD then one mem_we pulse; memory word=0xDEAD7FEF; rsp at T+3.
- Load signed byte @0x13 of 0x80001234 -> rsp_rdata=0xFFFFFF80; the same load unsigned -> 0x00000080.
- Load half @0x21, word @0x22, size=11 @0x0, and word @0x1000 (DEPTH=1024) -> each gives rsp_err=1, rsp_rdata=0 at T+1, mem_we never asserted.
- Hold rsp_ready=0 for 5 cycles on a load -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 while held.
- Then set rsp_ready=1 -> next request accepted the cycle after the handshake.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the memory stage and a word-addressed data memory.
// Handles sub-word stores by read-modify-write and extends sub-word loads.
module dmem_access_ctrl #(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [31:0]   mem_a,
    output logic [31:0]   mem_wd,
    output logic          mem_we,
    input  logic [31:0]   mem_rd
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [AW-3:0] DEPTH_W = (AW-2)'(DEPTH);

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   old_q, old_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          req_err;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_ext;
    logic [31:0]   merged;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)                          req_err = 1'b1;
        if (req_size == SZ_H && req_addr[0])            req_err = 1'b1;
        if (req_size == SZ_W && req_addr[1:0] != 2'b00) req_err = 1'b1;
        if (req_addr[AW-1:2] >= DEPTH_W)                req_err = 1'b1;
    end

    // Lane selection and extension of the word currently on mem_rd
    always_comb begin
        byte_sel = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        half_sel = mem_rd[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_B:    load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SZ_H:    load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_rd;
        endcase
    end

    always_comb begin
        merged = old_q;
        if (size_q == SZ_B) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        old_d   = old_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = req_err;
                    if (req_err)           state_d = RESP;
                    else if (!req_we)      state_d = LOAD;
                    else if (req_size == SZ_W) state_d = WRITE;
                    else                   state_d = RMW_RD;
                end
            end
            LOAD: begin
                rdata_d = load_ext;
                state_d = RESP;
            end
            RMW_RD: begin
                old_d   = mem_rd;
                state_d = WRITE;
            end
            WRITE:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory strobes decode straight from state so reset kills a write instantly
    always_comb begin
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        if (state_q == LOAD || state_q == RMW_RD || state_q == WRITE)
            mem_a = {addr_q[31:2], 2'b00};
        if (state_q == WRITE) begin
            mem_we = 1'b1;
            mem_wd = (size_q == SZ_W) ? wdata_q : merged;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    logic unused_ok;
    assign unused_ok = we_q;

endmodule
